// File: rtl/elc3_pkg.sv
// elc3_pkg: shared SRAM sequencer state type and bus widths
package elc3_pkg;
  localparam int SRAM_ADDR_W = 20;
  localparam int WORD_W = 16;
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, DONE} sram_state_t;
endpackage

// File: rtl/sram_controller.sv
// sram_controller: turns a one-cycle request into a registered CE/OE/WE/LB/UB sequence and DQ drive for one SRAM word
module sram_controller
  import elc3_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Req,
  input  logic                   R_W,
  input  logic [WORD_W-1:0]      Address,
  input  logic [WORD_W-1:0]      WrData,
  output logic [WORD_W-1:0]      RdData,
  output logic                   Ready,
  output logic                   Busy,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_UB_N,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [WORD_W-1:0]      SRAM_DQ
);
  localparam int CW = $clog2(WAIT_CYCLES + 1);
  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("sram_controller: WAIT_CYCLES must be in 1..15");
  end
  sram_state_t            state_q;
  logic [CW-1:0]          cnt_q;
  logic                   rw_q;
  logic [WORD_W-1:0]      wdata_q;
  logic [WORD_W-1:0]      rdata_q;
  logic [SRAM_ADDR_W-1:0] addr_q;
  logic                   ready_q;
  logic                   ce_n_q;
  logic                   oe_n_q;
  logic                   we_n_q;
  logic                   be_n_q;
  logic                   dq_oe_q;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      ready_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      be_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: if (Req) begin
          state_q <= SETUP;
          rw_q    <= R_W;
          wdata_q <= WrData;
          addr_q  <= {{(SRAM_ADDR_W - WORD_W){1'b0}}, Address};
          ce_n_q  <= 1'b0;
          be_n_q  <= 1'b0;
          dq_oe_q <= R_W;
        end
        SETUP: begin
          state_q <= ACCESS;
          cnt_q   <= CW'(WAIT_CYCLES - 1);
          oe_n_q  <= rw_q;
          we_n_q  <= ~rw_q;
        end
        ACCESS: if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        else if (rw_q) begin
          // WE_N rises first; CE, address and data stay put for data hold
          state_q <= HOLD;
          we_n_q  <= 1'b1;
        end else begin
          state_q <= DONE;
          rdata_q <= SRAM_DQ;
          ready_q <= 1'b1;
          oe_n_q  <= 1'b1;
          ce_n_q  <= 1'b1;
          be_n_q  <= 1'b1;
        end
        HOLD: begin
          state_q <= DONE;
          ready_q <= 1'b1;
          ce_n_q  <= 1'b1;
          be_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign SRAM_DQ   = dq_oe_q ? wdata_q : 'z;
  assign RdData    = rdata_q;
  assign Ready     = ready_q;
  assign Busy      = state_q != IDLE;
  assign SRAM_CE_N = ce_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_LB_N = be_n_q;
  assign SRAM_UB_N = be_n_q;
  assign SRAM_ADDR = addr_q;
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed vector table plus reset, busy-ignore and wait-parameter sequences
module tb_sram_controller;
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;
  logic Reset, R_W, req2, req1, req15;
  logic [15:0] Address, WrData;
  wire  [15:0] dq2, dq1, dq15;
  logic [15:0] rd2, rd1, rd15;
  logic rdy2, rdy1, rdy15, busy2, busy1, busy15;
  logic ce2, oe2, we2, lb2, ub2, ce1, oe1, we1, lb1, ub1, ce15, oe15, we15, lb15, ub15;
  logic [19:0] a2, a1, a15;
  sram_controller #(.WAIT_CYCLES(2)) dut (
    .Clk(Clk), .Reset(Reset), .Req(req2), .R_W(R_W), .Address(Address), .WrData(WrData),
    .RdData(rd2), .Ready(rdy2), .Busy(busy2), .SRAM_CE_N(ce2), .SRAM_OE_N(oe2), .SRAM_WE_N(we2),
    .SRAM_LB_N(lb2), .SRAM_UB_N(ub2), .SRAM_ADDR(a2), .SRAM_DQ(dq2));
  sram_controller #(.WAIT_CYCLES(1)) dut_w1 (
    .Clk(Clk), .Reset(Reset), .Req(req1), .R_W(R_W), .Address(Address), .WrData(WrData),
    .RdData(rd1), .Ready(rdy1), .Busy(busy1), .SRAM_CE_N(ce1), .SRAM_OE_N(oe1), .SRAM_WE_N(we1),
    .SRAM_LB_N(lb1), .SRAM_UB_N(ub1), .SRAM_ADDR(a1), .SRAM_DQ(dq1));
  sram_controller #(.WAIT_CYCLES(15)) dut_w15 (
    .Clk(Clk), .Reset(Reset), .Req(req15), .R_W(R_W), .Address(Address), .WrData(WrData),
    .RdData(rd15), .Ready(rdy15), .Busy(busy15), .SRAM_CE_N(ce15), .SRAM_OE_N(oe15), .SRAM_WE_N(we15),
    .SRAM_LB_N(lb15), .SRAM_UB_N(ub15), .SRAM_ADDR(a15), .SRAM_DQ(dq15));
  // SRAM models: a writable array behind the W=2 instance, fixed read patterns behind the others
  logic [15:0] mem [0:65535];
  always @(posedge Clk) if (!ce2 && !we2) mem[a2[15:0]] <= dq2;
  assign dq2  = (!ce2 && !oe2) ? mem[a2[15:0]] : 'z;
  assign dq1  = (!ce1 && !oe1) ? (a1[15:0] ^ 16'hA5A5) : 'z;
  assign dq15 = (!ce15 && !oe15) ? (a15[15:0] ^ 16'hA5A5) : 'z;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nrdy2 = 0;
  logic [15:0] last_rd = 16'h0000;
  always @(posedge Clk) cyc <= cyc + 1;
  always @(posedge Clk) if (rdy2 === 1'b1) nrdy2 <= nrdy2 + 1;
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  function automatic logic hiz(input logic [15:0] v);
    return (v === 16'hzzzz) || (v === 16'h0000);
  endfunction
  always @(negedge Clk) begin
    if (!Reset && cyc > 2) begin
      check("oe_we_excl", 32'((!oe2 && !we2) || (!oe1 && !we1) || (!oe15 && !we15)), 0);
      if (!oe2 && !ce2) check("dq_contention_w2", dq2, mem[a2[15:0]]);
      if (!oe1 && !ce1) check("dq_contention_w1", dq1, a1[15:0] ^ 16'hA5A5);
      if (!oe15 && !ce15) check("dq_contention_w15", dq15, a15[15:0] ^ 16'hA5A5);
    end
  end
  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    int          lat;
    logic        intr;
  } vec_t;
  vec_t v [10];
  int rcyc [10];
  task automatic access(input vec_t t, output int rc);
    int n_rdy, n_we, n_oe, first_lo, seen;
    logic [15:0] exp_rd;
    n_rdy = 0; n_we = 0; n_oe = 0; first_lo = 0; seen = -1; rc = -1;
    exp_rd = t.rw ? last_rd : t.exp_rd;
    req2 = 1'b1; R_W = t.rw; Address = t.addr; WrData = t.wdata;
    @(posedge Clk);
    #1;
    req2 = 1'b0; R_W = ~t.rw; Address = ~t.addr; WrData = ~t.wdata;
    for (int n = 1; n <= t.lat + 1; n++) begin
      @(negedge Clk);
      if (t.intr && n == 2) begin req2 = 1'b1; R_W = 1'b0; Address = 16'h1234; end
      if (t.intr && n == 3) req2 = 1'b0;
      if (!we2) n_we++;
      if (!oe2) n_oe++;
      if ((!we2 || !oe2) && first_lo == 0) first_lo = n;
      if (rdy2) begin n_rdy++; if (seen < 0) begin seen = n; rc = cyc; end end
      if (n <= t.lat) check("sram_addr", a2, {4'h0, t.addr});
      if (n == 1) begin
        check("setup_strobes", {ce2, lb2, ub2, oe2, we2, busy2}, 6'b000111);
        if (!t.rw) check("setup_dq_hiz_rd", hiz(dq2), 1);
      end
      if (t.rw && n <= t.lat - 1) check("wr_dq_driven", dq2, t.wdata);
      if (n == t.lat) begin
        check("done_strobes", {ce2, oe2, we2, lb2, ub2, busy2, rdy2}, 7'b1111111);
        check("done_dq_hiz", hiz(dq2), 1);
        check("rddata", rd2, exp_rd);
      end
      if (n == t.lat + 1) check("idle_after_done", {busy2, rdy2}, 2'b00);
    end
    check("latency", seen, t.lat);
    check("ready_count", n_rdy, 1);
    check("we_cycles", n_we, t.rw ? 2 : 0);
    check("oe_cycles", n_oe, t.rw ? 0 : 2);
    check("strobe_start", first_lo, 2);
    last_rd = exp_rd;
  endtask
  task automatic probe(input logic big, input logic [15:0] ad, input int lat);
    int seen;
    seen = -1;
    if (big) req15 = 1'b1; else req1 = 1'b1;
    R_W = 1'b0; Address = ad;
    @(posedge Clk);
    #1;
    req1 = 1'b0; req15 = 1'b0; Address = ~ad;
    for (int n = 1; n <= lat + 1; n++) begin
      @(negedge Clk);
      if ((big ? rdy15 : rdy1) && seen < 0) seen = n;
    end
    check(big ? "latency_w15" : "latency_w1", seen, lat);
    check(big ? "rddata_w15" : "rddata_w1", big ? rd15 : rd1, ad ^ 16'hA5A5);
    check(big ? "busy_w15_idle" : "busy_w1_idle", big ? busy15 : busy1, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", cyc);
    $fatal(1);
  end
  initial begin
    v[0] = '{1'b1, 16'h3000, 16'hBEEF, 16'h0000, 5, 1'b0};
    v[1] = '{1'b0, 16'h3000, 16'h0000, 16'hBEEF, 4, 1'b0};
    v[2] = '{1'b1, 16'h0000, 16'h0F0F, 16'h0000, 5, 1'b0};
    v[3] = '{1'b1, 16'hFFFF, 16'hF0F0, 16'h0000, 5, 1'b0};
    v[4] = '{1'b1, 16'h1234, 16'h5A5A, 16'h0000, 5, 1'b0};
    v[5] = '{1'b0, 16'h0000, 16'h0000, 16'h0F0F, 4, 1'b0};
    v[6] = '{1'b0, 16'hFFFF, 16'h0000, 16'hF0F0, 4, 1'b0};
    v[7] = '{1'b1, 16'h2000, 16'h1111, 16'h0000, 5, 1'b1};
    v[8] = '{1'b0, 16'h1234, 16'h0000, 16'h5A5A, 4, 1'b0};
    v[9] = '{1'b0, 16'h2000, 16'h0000, 16'h1111, 4, 1'b0};
    Reset = 1'b1; req2 = 1'b1; req1 = 1'b1; req15 = 1'b1;
    R_W = 1'b1; Address = 16'h3000; WrData = 16'hBEEF;
    repeat (2) @(negedge Clk);
    check("rst_strobes", {ce2, oe2, we2, lb2, ub2}, 5'h1f);
    check("rst_outputs", {busy2, rdy2, rd2}, 18'h0);
    check("rst_addr", a2, 0);
    check("rst_dq_hiz", hiz(dq2), 1);
    check("rst_w1", {ce1, oe1, we1, lb1, ub1, busy1, rdy1, rd1, a1}, {5'h1f, 38'h0});
    check("rst_w15", {ce15, oe15, we15, lb15, ub15, busy15, rdy15, rd15, a15}, {5'h1f, 38'h0});
    Reset = 1'b0; req2 = 1'b0; req1 = 1'b0; req15 = 1'b0;
    @(negedge Clk);
    check("idle_after_rst", {busy2, rdy2, ce2}, 3'b001);
    for (int i = 0; i < 10; i++) begin
      access(v[i], rcyc[i]);
      if (i > 0) check("ready_spacing", rcyc[i] - rcyc[i-1], v[i].lat + 1);
    end
    req2 = 1'b1; R_W = 1'b1; Address = 16'h4000; WrData = 16'h7777;
    @(posedge Clk);
    #1 req2 = 1'b0;
    repeat (2) @(negedge Clk);
    check("mid_access_we_low", we2, 0);
    Reset = 1'b1;
    @(negedge Clk);
    check("mid_rst_strobes", {ce2, oe2, we2, lb2, ub2}, 5'h1f);
    check("mid_rst_busy_rdy", {busy2, rdy2}, 2'b00);
    check("mid_rst_dq_hiz", hiz(dq2), 1);
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check("mid_rst_no_ready", {busy2, rdy2}, 2'b00);
    end
    probe(1'b0, 16'h00C3, 3);
    probe(1'b1, 16'h7E81, 17);
    check("total_ready_pulses", nrdy2, 10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
